// File: rtl/source_dispense_sequencer.sv
// Source dispense sequencer: meters Source fluid into up to NUM_OUT inlets, one channel at a time (valve + 3-phase pump).
// Latency: SCAN one cycle after start; per serviced channel SETTLE_CYC open + strokes*3*PHASE_CYC pump + SETTLE_CYC close.
// Backpressure: none; start and cfg_we are ignored while busy, abort overrides every non-IDLE state.
module source_dispense_sequencer #(
  parameter int NUM_OUT    = 8,
  parameter int CNT_W      = 8,
  parameter int PHASE_CYC  = 4,
  parameter int SETTLE_CYC = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [$clog2(NUM_OUT)-1:0] cfg_addr,
  input  logic [CNT_W-1:0]           cfg_strokes,
  input  logic                       start,
  input  logic                       abort,
  output logic [NUM_OUT-1:0]         valve_en,
  output logic [2:0]                 pump_phase,
  output logic                       stroke_tick,
  output logic [$clog2(NUM_OUT)-1:0] cur_ch,
  output logic                       busy,
  output logic                       done,
  output logic                       aborted
);

  localparam int AW     = $clog2(NUM_OUT);
  localparam int TMAX   = (PHASE_CYC > SETTLE_CYC) ? PHASE_CYC : SETTLE_CYC;
  localparam int TW     = $clog2(TMAX + 1);
  localparam logic [AW-1:0] LAST_CH = AW'(NUM_OUT - 1);
  localparam logic [TW-1:0] SET_END = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] PH_END  = TW'(PHASE_CYC - 1);
  // One bit per encodable address; bits at or above NUM_OUT are 0 so such writes drop.
  localparam logic [(2**AW)-1:0] ADDR_OK = {(2**AW){1'b1}} >> ((2**AW) - NUM_OUT);
  localparam logic [NUM_OUT-1:0] ONE_HOT0 = {{(NUM_OUT-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, SCAN, OPEN, PUMP, CLOSE, DONE} state_t;

  state_t           state;
  logic [AW-1:0]    ch;
  logic [TW-1:0]    tmr;      // settle / phase hold timer, restarted on every phase change
  logic [CNT_W-1:0] strokes;  // strokes completed on the current channel
  logic [CNT_W-1:0] tgt;      // stroke target latched when the channel is scanned
  logic [CNT_W-1:0] tbl [NUM_OUT];

  // Status outputs are pure decodes of registered state, so they carry no input paths.
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign stroke_tick = (state == PUMP) && pump_phase[2] && (tmr == PH_END);
  assign cur_ch      = ch;

  // Sequencer FSM, stroke table and registered valve/pump drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ch         <= '0;
      tmr        <= '0;
      strokes    <= '0;
      tgt        <= '0;
      valve_en   <= '0;
      pump_phase <= '0;
      aborted    <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) tbl[i] <= '0;
    end else begin
      aborted <= 1'b0;
      if ((state != IDLE) && abort) begin
        state      <= IDLE;
        valve_en   <= '0;
        pump_phase <= '0;
        tmr        <= '0;
        aborted    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (cfg_we && ADDR_OK[cfg_addr]) tbl[cfg_addr] <= cfg_strokes;
            if (start && !abort) begin
              state <= SCAN;
              ch    <= '0;
            end
          end
          SCAN: begin
            if (tbl[ch] != '0) begin
              tgt      <= tbl[ch];
              valve_en <= ONE_HOT0 << ch;
              tmr      <= '0;
              state    <= OPEN;
            end else if (ch == LAST_CH) begin
              state <= DONE;
            end else begin
              ch <= ch + 1'b1;
            end
          end
          OPEN: begin
            if (tmr == SET_END) begin
              tmr        <= '0;
              strokes    <= '0;
              pump_phase <= 3'b001;
              state      <= PUMP;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          PUMP: begin
            if (tmr == PH_END) begin
              tmr <= '0;
              case (pump_phase)
                3'b001:  pump_phase <= 3'b010;
                3'b010:  pump_phase <= 3'b100;
                default: begin
                  // Stroke ends here; the counter never passes tgt so max count cannot wrap.
                  strokes <= strokes + 1'b1;
                  if ((strokes + 1'b1) == tgt) begin
                    pump_phase <= 3'b000;
                    valve_en   <= '0;
                    state      <= CLOSE;
                  end else begin
                    pump_phase <= 3'b001;
                  end
                end
              endcase
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          CLOSE: begin
            if (tmr == SET_END) begin
              tmr <= '0;
              if (ch == LAST_CH) begin
                state <= DONE;
              end else begin
                ch    <= ch + 1'b1;
                state <= SCAN;
              end
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          default: state <= IDLE;  // DONE: one-cycle completion pulse
        endcase
      end
    end
  end

endmodule

// File: tb/tb_source_dispense_sequencer.sv
// Bench for source_dispense_sequencer: table-driven cycle vectors plus directed multi-cycle sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_source_dispense_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [7:0] cfg_strokes = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] valve_en;
  logic [2:0] pump_phase;
  logic       stroke_tick;
  logic [2:0] cur_ch;
  logic       busy, done, aborted;

  source_dispense_sequencer #(.NUM_OUT(8), .CNT_W(8), .PHASE_CYC(2), .SETTLE_CYC(3)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_strokes(cfg_strokes),
    .start(start), .abort(abort), .valve_en(valve_en), .pump_phase(pump_phase),
    .stroke_tick(stroke_tick), .cur_ch(cur_ch), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Results of the most recent run_seq call
  logic [7:0] v_first, v_second;
  int v_first_cyc, min_gap, done_cyc, done_cnt, abort_cnt, overlap, any_valve, any_phase, busy_after;
  int ticks [8];

  typedef struct {
    int         cyc;
    logic [7:0] valve;
    logic [2:0] phase;
    logic       tk;
    logic       bsy;
    logic       dn;
    logic [2:0] ch;
  } vec_t;
  vec_t vt [19];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic cfg(input logic [2:0] a, input logic [7:0] v);
    cfg_we = 1'b1; cfg_addr = a; cfg_strokes = v;
    tick();
    cfg_we = 1'b0;
  endtask

  function automatic logic [31:0] outs();
    return {15'd0, valve_en, pump_phase, stroke_tick, busy, done, aborted, cur_ch};
  endfunction

  // Start a sequence and observe it until done (bounded). inj>0 drives a cfg write to ch1
  // plus a start at that cycle of the run, both of which must be ignored while busy.
  task automatic run_seq(input int inj);
    int cyc, gap, nv;
    logic [7:0] prev;
    v_first = '0; v_second = '0; v_first_cyc = -1; min_gap = 1000; done_cyc = -1;
    done_cnt = 0; abort_cnt = 0; overlap = 0; any_valve = 0; any_phase = 0;
    for (int i = 0; i < 8; i++) ticks[i] = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1; gap = -1; nv = 0; prev = '0;
    while (done_cyc < 0 && cyc < 3000) begin
      if (cyc == inj) begin
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_strokes = 8'd7; start = 1'b1;
      end
      if ($countones(valve_en) > 1) overlap = 1;
      if (valve_en != 0 && prev == 0) begin
        if (nv == 0) begin v_first = valve_en; v_first_cyc = cyc; end
        else if (nv == 1) v_second = valve_en;
        nv++;
        if (gap >= 0 && gap < min_gap) min_gap = gap;
      end
      if (valve_en == 0) begin
        if (prev != 0) gap = 1;
        else if (gap >= 0) gap++;
      end
      if (stroke_tick)
        for (int i = 0; i < 8; i++) if (valve_en[i]) ticks[i]++;
      if (valve_en != 0) any_valve = 1;
      if (pump_phase != 0) any_phase = 1;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (aborted) abort_cnt++;
      prev = valve_en;
      tick();
      cfg_we = 1'b0; start = 1'b0;
      cyc++;
    end
    busy_after = int'(busy) + 2 * int'(done);
  endtask

  initial begin
    int vi, cyc, w;
    logic seen_done;

    //            cyc  valve   phase   tick  busy  done  cur_ch
    vt[0]  = '{ 1, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 3'd0};
    vt[1]  = '{ 2, 8'h01, 3'b000, 1'b0, 1'b1, 1'b0, 3'd0};
    vt[2]  = '{ 4, 8'h01, 3'b000, 1'b0, 1'b1, 1'b0, 3'd0};
    vt[3]  = '{ 5, 8'h01, 3'b001, 1'b0, 1'b1, 1'b0, 3'd0};
    vt[4]  = '{ 6, 8'h01, 3'b001, 1'b0, 1'b1, 1'b0, 3'd0};
    vt[5]  = '{ 7, 8'h01, 3'b010, 1'b0, 1'b1, 1'b0, 3'd0};
    vt[6]  = '{ 8, 8'h01, 3'b010, 1'b0, 1'b1, 1'b0, 3'd0};
    vt[7]  = '{ 9, 8'h01, 3'b100, 1'b0, 1'b1, 1'b0, 3'd0};
    vt[8]  = '{10, 8'h01, 3'b100, 1'b1, 1'b1, 1'b0, 3'd0};
    vt[9]  = '{11, 8'h01, 3'b001, 1'b0, 1'b1, 1'b0, 3'd0};
    vt[10] = '{13, 8'h01, 3'b010, 1'b0, 1'b1, 1'b0, 3'd0};
    vt[11] = '{15, 8'h01, 3'b100, 1'b0, 1'b1, 1'b0, 3'd0};
    vt[12] = '{16, 8'h01, 3'b100, 1'b1, 1'b1, 1'b0, 3'd0};
    vt[13] = '{17, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 3'd0};
    vt[14] = '{19, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 3'd0};
    vt[15] = '{20, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 3'd1};
    vt[16] = '{26, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 3'd7};
    vt[17] = '{27, 8'h00, 3'b000, 1'b0, 1'b1, 1'b1, 3'd7};
    vt[18] = '{28, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 3'd7};

    // Reset state
    #3;
    check("reset_outputs", outs(), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single channel, two strokes: cycle-exact vectors
    cfg(3'd0, 8'd2);
    start = 1'b1;
    cyc = 0;
    vi = 0;
    while (vi < 19) begin
      tick();
      start = 1'b0;
      cyc++;
      if (cyc == vt[vi].cyc) begin
        check($sformatf("vec_cyc%0d", vt[vi].cyc),
              {15'd0, valve_en, pump_phase, stroke_tick, busy, done, cur_ch},
              {15'd0, vt[vi].valve, vt[vi].phase, vt[vi].tk, vt[vi].bsy, vt[vi].dn, vt[vi].ch});
        vi++;
      end
    end

    // Two channels: order, stroke totals, no overlap, close-to-open gap
    do_reset();
    cfg(3'd2, 8'd1);
    cfg(3'd5, 8'd3);
    run_seq(0);
    check("two_first_valve", 32'(v_first), 32'h04);
    check("two_second_valve", 32'(v_second), 32'h20);
    check("two_ticks_ch2", 32'(ticks[2]), 32'd1);
    check("two_ticks_ch5", 32'(ticks[5]), 32'd3);
    check("two_overlap", 32'(overlap), 32'd0);
    check("two_gap", 32'(min_gap), 32'd6);
    check("two_done_cyc", 32'(done_cyc), 32'd45);
    check("two_busy_after", 32'(busy_after), 32'd0);

    // Empty table: done NUM_OUT+1 cycles after start, outputs quiet
    do_reset();
    run_seq(0);
    check("empty_done_cyc", 32'(done_cyc), 32'd9);
    check("empty_no_valve", 32'(any_valve), 32'd0);
    check("empty_no_phase", 32'(any_phase), 32'd0);

    // Abort in IDLE suppresses a same-cycle start
    do_reset();
    cfg(3'd3, 8'd255);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd0);
    check("idle_abort_pulse", 32'(aborted), 32'd0);

    // Abort during the 100 phase of a stroke
    start = 1'b1;
    tick();
    start = 1'b0;
    w = 0; seen_done = 1'b0;
    while (pump_phase != 3'b100 && w < 200) begin
      if (done) seen_done = 1'b1;
      tick();
      w++;
    end
    check("abort_reach_phase100", 32'(pump_phase), 32'h4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_outputs", {15'd0, valve_en, pump_phase, aborted, busy, done},
          {15'd0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0});
    tick();
    if (done) seen_done = 1'b1;
    check("abort_pulse_1cyc", 32'(aborted), 32'd0);
    check("abort_no_done", 32'(seen_done), 32'd0);

    // Rerun after abort: table intact, restarts at ch0, 255 strokes without wrap
    run_seq(0);
    check("rerun_valve", 32'(v_first), 32'h08);
    check("rerun_open_cyc", 32'(v_first_cyc), 32'd5);
    check("max_ticks_ch3", 32'(ticks[3]), 32'd255);
    check("max_done_cyc", 32'(done_cyc), 32'd1545);
    check("max_no_abort", 32'(abort_cnt), 32'd0);

    // cfg_we and start while busy are ignored
    do_reset();
    cfg(3'd1, 8'd2);
    run_seq(4);
    check("busy_ign_done_cyc", 32'(done_cyc), 32'd27);
    check("busy_ign_ticks", 32'(ticks[1]), 32'd2);
    check("busy_ign_done_cnt", 32'(done_cnt), 32'd1);
    check("busy_ign_after", 32'(busy_after), 32'd0);
    run_seq(0);
    check("busy_ign_rerun_ticks", 32'(ticks[1]), 32'd2);

    // Reset asserted mid-PUMP clears outputs at once and empties the table
    start = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (pump_phase == 3'b000 && w < 200) begin
      tick();
      w++;
    end
    check("rst_reach_pump", 32'(pump_phase != 3'b000), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", outs(), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_seq(0);
    check("rst_empty_done_cyc", 32'(done_cyc), 32'd9);
    check("rst_empty_no_valve", 32'(any_valve), 32'd0);
    check("rst_empty_no_abort", 32'(abort_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/source_dispense_sequencer.md
Name: source_dispense_sequencer

Overview:
- Digital controller directly upstream of the first-row chamber/heater/filter inlets fed from a common Source port.
- Meters Source fluid into up to NUM_OUT inlet channels, one channel at a time.
- For each channel it opens that channel's inlet valve and drives a 3-phase peristaltic pump for a programmed number of strokes.
- Provides a start/busy/done handshake and an abort path.

Parameters:
NUM_OUT, 8, number of inlet channels (2..16)
CNT_W, 8, width of per-channel stroke count
PHASE_CYC, 4, clock cycles each pump phase is held (>=1)
SETTLE_CYC, 3, cycles a valve is held before pumping and after closing (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cfg_we  input  1  write stroke count for channel cfg_addr
cfg_addr  input  clog2(NUM_OUT)  channel index
cfg_strokes  input  CNT_W  stroke count; 0 = skip channel
start  input  1  begin dispense sequence (sampled in IDLE only)
abort  input  1  stop immediately
valve_en  output  NUM_OUT  one-hot inlet valve drive
pump_phase  output  3  peristaltic phase drive, one-hot or 000
stroke_tick  output  1  1-cycle pulse at the end of each completed stroke
cur_ch  output  clog2(NUM_OUT)  channel currently being serviced
busy  output  1  high in every state except IDLE
done  output  1  1-cycle pulse when the sequence completes normally
aborted  output  1  1-cycle pulse when abort terminates a sequence

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, all outputs 0, cur_ch=0.
  - Stroke table cleared to 0; all internal counters cleared.
- Config writes:
  - cfg_we accepted only in IDLE; the value is visible to a start in the following cycle.
  - cfg_we while busy is ignored.
  - cfg_addr >= NUM_OUT is ignored.
- States: IDLE, SCAN, OPEN, PUMP, CLOSE, DONE.
- IDLE:
  - start=1 (and abort=0) -> SCAN with ch=0.
  - start while busy is ignored.
- SCAN (1 cycle per channel):
  - count[ch]!=0 -> OPEN.
  - count[ch]==0 and ch<NUM_OUT-1 -> ch+1, stay in SCAN.
  - count[ch]==0 and ch==NUM_OUT-1 -> DONE.
- OPEN:
  - valve_en=1<<ch, pump_phase=000, held SETTLE_CYC cycles, then -> PUMP with stroke counter=0.
- PUMP:
  - valve_en held.
  - pump_phase sequences 001, 010, 100, each held PHASE_CYC cycles.
  - On the last cycle of 100: stroke_tick=1 and stroke counter increments.
  - If the new stroke count equals count[ch] -> CLOSE; otherwise restart at 001.
  - No idle cycle between strokes.
- CLOSE:
  - valve_en=0, pump_phase=000 for SETTLE_CYC cycles.
  - Then: ch==NUM_OUT-1 -> DONE; otherwise ch+1 -> SCAN.
- DONE: done=1 for one cycle, busy=1; next state IDLE.
- At most one valve is open at any time.
- valve_en and pump_phase are registered outputs.
- Counts are latched per channel at the start of that channel; the table is frozen while busy, so there is no mid-run change.
- cur_ch tracks ch in SCAN/OPEN/PUMP/CLOSE and holds its last value in DONE/IDLE.
- Max count (2^CNT_W-1) must complete without wrap.
- abort:
  - Highest priority in any non-IDLE state.
  - Next cycle: state=IDLE, valve_en=0, pump_phase=000, aborted=1 for one cycle, done is not pulsed.
  - abort in IDLE does nothing, and suppresses a same-cycle start.
- Reset asserted mid-run: outputs go to 0 immediately (asynchronously) and the table is cleared.
- All counters saturate or reset by state; no free-running wrap.

Test Plan:
- Defaults except PHASE_CYC=2, SETTLE_CYC=3; count[0]=2, others 0; start pulse at cycle 0 ->
  - SCAN cycle 1; valve_en=0x01 during cycles 2-16.
  - Pump phases 001,001,010,010,100,100 twice over cycles 5-16; stroke_tick at cycles 10 and 16.
  - CLOSE cycles 17-19; SCAN ch1..7 cycles 20-26; done=1 at cycle 27; busy low at cycle 28.
- count[2]=1, count[5]=3, others 0 ->
  - Valve order 0x04 then 0x20; stroke_tick totals 1 and 3.
  - Valves never overlap; all-closed gap of >= SETTLE_CYC cycles between them.
- All counts 0, start -> done pulse exactly NUM_OUT+1 cycles after start; valve_en and pump_phase stay 0.
- count[3]=255; abort during PUMP stroke 100 ->
  - Next cycle valve_en=0, pump=000, aborted=1, done never asserted.
  - A later start reruns from ch0 with the table intact.
- cfg_we (addr 1, value 7) while busy, plus start while busy -> both ignored; table readback by a rerun shows the old count for ch1.
- rst_n low mid-PUMP -> outputs 0 in the same cycle, no done/aborted pulse; start after release with empty table -> done only.
